// File: rtl/y_req_master.sv
// Sweeps operand pairs through an external compute device and queues results in a FWFT FIFO.
// Stalls when the FIFO is full; define Y_REQ_TIMEOUT_EN to enable the device watchdog and err_o.
module y_req_master #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        go_i,
  input  logic [7:0]  a_start_bi,
  input  logic [7:0]  b_start_bi,
  input  logic [3:0]  count_bi,
  output logic [7:0]  dev_a_bo,
  output logic [7:0]  dev_b_bo,
  output logic        dev_start_o,
  input  logic        dev_busy_i,
  input  logic [15:0] dev_res_bi,
  input  logic        rd_i,
  output logic [15:0] fifo_data_bo,
  output logic        fifo_empty_o,
  output logic        fifo_full_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_ACK, WAIT_DONE, STORE, STALL} state_t;

  state_t        r_state;
  logic [7:0]    r_a;
  logic [7:0]    r_b;
  logic [4:0]    r_rem;
  logic [15:0]   r_res;
  logic          r_start;
  logic          r_done;
  logic [15:0]   r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wp;
  logic [AW-1:0] r_rp;
  logic [CW-1:0] r_cnt;
  logic          w_full;
  logic          w_empty;
  logic          w_push;
  logic          w_pop;

  assign w_full  = (r_cnt == CW'(FIFO_DEPTH));
  assign w_empty = (r_cnt == '0);
  assign w_pop   = rd_i && !w_empty;
  // A pop from a full FIFO frees the slot the stalled result needs on the same edge.
  assign w_push  = ((r_state == STORE) && !w_full) ||
                   ((r_state == STALL) && (!w_full || rd_i));

  assign dev_a_bo     = r_a;
  assign dev_b_bo     = r_b;
  assign dev_start_o  = r_start;
  assign busy_o       = (r_state != IDLE);
  assign done_o       = r_done;
  assign fifo_empty_o = w_empty;
  assign fifo_full_o  = w_full;
  assign fifo_data_bo = w_empty ? 16'd0 : r_mem[r_rp];

`ifdef Y_REQ_TIMEOUT_EN
  logic [7:0] r_wdog;
  logic       r_err;
  assign err_o = r_err;
`else
  assign err_o = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state <= IDLE;
      r_a     <= 8'd0;
      r_b     <= 8'd0;
      r_rem   <= 5'd0;
      r_res   <= 16'd0;
      r_start <= 1'b0;
      r_done  <= 1'b0;
`ifdef Y_REQ_TIMEOUT_EN
      r_wdog  <= 8'd0;
      r_err   <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (go_i) begin
            r_a     <= a_start_bi;
            r_b     <= b_start_bi;
            r_rem   <= (count_bi == 4'd0) ? 5'd16 : {1'b0, count_bi};
            r_start <= 1'b1;
            r_state <= ISSUE;
`ifdef Y_REQ_TIMEOUT_EN
            r_err   <= 1'b0;
`endif
          end
        end
        ISSUE: begin
          r_state <= WAIT_ACK;
`ifdef Y_REQ_TIMEOUT_EN
          r_wdog  <= 8'd0;
`endif
        end
        WAIT_ACK: begin
          if (dev_busy_i) begin
            r_start <= 1'b0;
            r_state <= WAIT_DONE;
`ifdef Y_REQ_TIMEOUT_EN
            r_wdog  <= 8'd0;
          end else if (r_wdog == 8'd15) begin
            r_start <= 1'b0;
            r_state <= IDLE;
            r_done  <= 1'b1;
            r_err   <= 1'b1;
          end else begin
            r_wdog  <= r_wdog + 8'd1;
`endif
          end
        end
        WAIT_DONE: begin
          if (!dev_busy_i) begin
            r_res   <= dev_res_bi;
            r_state <= STORE;
`ifdef Y_REQ_TIMEOUT_EN
          end else if (r_wdog == 8'd255) begin
            r_state <= IDLE;
            r_done  <= 1'b1;
            r_err   <= 1'b1;
          end else begin
            r_wdog  <= r_wdog + 8'd1;
`endif
          end
        end
        STORE, STALL: begin
          if (w_push) begin
            r_a   <= r_a + 8'd1;
            r_b   <= r_b + 8'd1;
            r_rem <= r_rem - 5'd1;
            if (r_rem == 5'd1) begin
              r_state <= IDLE;
              r_done  <= 1'b1;
            end else begin
              r_state <= ISSUE;
              r_start <= 1'b1;
            end
          end else begin
            r_state <= STALL;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wp <= r_wp + 1'b1;
      if (w_pop)  r_rp <= r_rp + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_push) r_mem[r_wp] <= r_res;
  end

endmodule

// File: tb/tb_y_req_master.sv
// Directed bench for y_req_master with a behavioural compute device (result = a*a + isqrt(b)).
module tb_y_req_master;
  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic        go_i = 1'b0;
  logic [7:0]  a_start_bi = 8'd0;
  logic [7:0]  b_start_bi = 8'd0;
  logic [3:0]  count_bi = 4'd0;
  logic [7:0]  dev_a_bo;
  logic [7:0]  dev_b_bo;
  logic        dev_start_o;
  logic        dev_busy_i;
  logic [15:0] dev_res_bi;
  logic        rd_i = 1'b0;
  logic [15:0] fifo_data_bo;
  logic        fifo_empty_o;
  logic        fifo_full_o;
  logic        busy_o;
  logic        done_o;
  logic        err_o;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int done_cnt = 0;
  int n_starts = 0;
  logic [7:0] a_log [64];
  logic [7:0] b_log [64];
  bit dev_en = 1'b1;
  int dev_lat = 1;
  int m_ph = 0;
  int m_left = 0;
  logic [7:0] m_a;
  logic [7:0] m_b;

  y_req_master #(.FIFO_DEPTH(4)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .go_i(go_i),
    .a_start_bi(a_start_bi), .b_start_bi(b_start_bi), .count_bi(count_bi),
    .dev_a_bo(dev_a_bo), .dev_b_bo(dev_b_bo), .dev_start_o(dev_start_o),
    .dev_busy_i(dev_busy_i), .dev_res_bi(dev_res_bi), .rd_i(rd_i),
    .fifo_data_bo(fifo_data_bo), .fifo_empty_o(fifo_empty_o), .fifo_full_o(fifo_full_o),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) begin
    cyc <= cyc + 1;
    if (done_o) done_cnt <= done_cnt + 1;
  end

  function automatic int isqrt(input int v);
    int r = 0;
    while ((r + 1) * (r + 1) <= v) r++;
    return r;
  endfunction

  function automatic logic [15:0] dres(input logic [7:0] a, input logic [7:0] b);
    int ai = int'(a);
    return 16'(ai * ai + isqrt(int'(b)));
  endfunction

  // Device: raises busy on start, holds it until start has dropped and the latency has elapsed.
  always @(negedge clk_i) begin
    if (!rst_i) begin
      dev_busy_i = 1'b0;
      m_ph = 0;
    end else if (m_ph == 0) begin
      if (dev_en && dev_start_o) begin
        dev_busy_i = 1'b1;
        m_a = dev_a_bo;
        m_b = dev_b_bo;
        m_left = dev_lat;
        a_log[n_starts % 64] = dev_a_bo;
        b_log[n_starts % 64] = dev_b_bo;
        n_starts++;
        m_ph = 1;
      end
    end else begin
      if (m_left > 0) m_left--;
      if (m_left == 0 && !dev_start_o) begin
        dev_busy_i = 1'b0;
        dev_res_bi = dres(m_a, m_b);
        m_ph = 0;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk_i);
    #1;
  endtask

  task automatic start_sweep(input logic [7:0] a, input logic [7:0] b, input logic [3:0] c);
    a_start_bi = a;
    b_start_bi = b;
    count_bi = c;
    go_i = 1'b1;
    tick(1);
    go_i = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    bit seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick(1);
      if (done_o) begin
        seen = 1'b1;
        break;
      end
    end
    check("done_seen", 32'(seen), 32'd1);
  endtask

  task automatic pop_check(input string tag, input logic [15:0] exp);
    check(tag, 32'(fifo_data_bo), 32'(exp));
    rd_i = 1'b1;
    tick(1);
    rd_i = 1'b0;
  endtask

  initial begin
    int s0;
    int d0;
    int idx;
    int c0;

    #1;
    check("rst_busy", 32'(busy_o), 32'd0);
    check("rst_empty", 32'(fifo_empty_o), 32'd1);
    check("rst_full", 32'(fifo_full_o), 32'd0);
    check("rst_data", 32'(fifo_data_bo), 32'd0);
    check("rst_start", 32'(dev_start_o), 32'd0);
    check("rst_done", 32'(done_o), 32'd0);
    check("rst_err", 32'(err_o), 32'd0);
    check("rst_dev_a", 32'(dev_a_bo), 32'd0);
    tick(2);
    rst_i = 1'b1;
    tick(1);

    // Basic two-op sweep.
    s0 = n_starts; d0 = done_cnt;
    start_sweep(8'd3, 8'd16, 4'd2);
    check("t1_issue_start", 32'(dev_start_o), 32'd1);
    check("t1_issue_a", 32'(dev_a_bo), 32'd3);
    check("t1_issue_b", 32'(dev_b_bo), 32'd16);
    wait_done(100);
    tick(3);
    check("t1_starts", 32'(n_starts - s0), 32'd2);
    check("t1_dones", 32'(done_cnt - d0), 32'd1);
    check("t1_busy_after", 32'(busy_o), 32'd0);
    pop_check("t1_res0", dres(8'd3, 8'd16));
    pop_check("t1_res1", dres(8'd4, 8'd17));
    check("t1_empty", 32'(fifo_empty_o), 32'd1);

    // Operand wrap plus a go pulse mid-sweep that must be ignored.
    dev_lat = 6;
    s0 = n_starts; d0 = done_cnt;
    start_sweep(8'd255, 8'd255, 4'd2);
    check("t2_issue_a", 32'(dev_a_bo), 32'd255);
    tick(4);
    start_sweep(8'd50, 8'd60, 4'd9);
    wait_done(200);
    tick(3);
    check("t2_starts", 32'(n_starts - s0), 32'd2);
    check("t2_wrap_a", 32'(a_log[(s0 + 1) % 64]), 32'd0);
    check("t2_wrap_b", 32'(b_log[(s0 + 1) % 64]), 32'd0);
    check("t2_dones", 32'(done_cnt - d0), 32'd1);
    pop_check("t2_res0", dres(8'd255, 8'd255));
    pop_check("t2_res1", dres(8'd0, 8'd0));
    check("t2_empty", 32'(fifo_empty_o), 32'd1);
    dev_lat = 1;

    // Sixteen-op sweep with the host idle: must stall on a full FIFO.
    s0 = n_starts; d0 = done_cnt;
    start_sweep(8'd10, 8'd100, 4'd0);
    idx = 0;
    for (int i = 0; i < 300; i++) begin
      if (fifo_full_o) break;
      tick(1);
    end
    tick(20);
    check("t3_full", 32'(fifo_full_o), 32'd1);
    check("t3_busy", 32'(busy_o), 32'd1);
    check("t3_stall_starts", 32'(n_starts - s0), 32'd5);
    pop_check("t3_pop0", dres(8'd10, 8'd100));
    idx = 1;
    tick(20);
    check("t3_resume_starts", 32'(n_starts - s0), 32'd6);
    check("t3_full_again", 32'(fifo_full_o), 32'd1);
    for (int i = 0; i < 1000; i++) begin
      if (idx == 16) break;
      if (!fifo_empty_o) begin
        check("t3_pop", 32'(fifo_data_bo), 32'(dres(8'(10 + idx), 8'(100 + idx))));
        rd_i = 1'b1;
        idx++;
      end else begin
        rd_i = 1'b0;
      end
      tick(1);
    end
    rd_i = 1'b0;
    tick(3);
    check("t3_popped", 32'(idx), 32'd16);
    check("t3_starts", 32'(n_starts - s0), 32'd16);
    check("t3_dones", 32'(done_cnt - d0), 32'd1);
    check("t3_empty", 32'(fifo_empty_o), 32'd1);
    check("t3_idle", 32'(busy_o), 32'd0);

    // Reset while the device is working on an operation.
    dev_lat = 20;
    start_sweep(8'd7, 8'd8, 4'd1);
    tick(4);
    check("t4_in_wait_done", 32'(busy_o & ~dev_start_o), 32'd1);
    rst_i = 1'b0;
    #1;
    check("t4_rst_start", 32'(dev_start_o), 32'd0);
    check("t4_rst_busy", 32'(busy_o), 32'd0);
    check("t4_rst_empty", 32'(fifo_empty_o), 32'd1);
    check("t4_rst_dev_a", 32'(dev_a_bo), 32'd0);
    tick(2);
    // Release and go together: the sweep must start on the first edge.
    dev_en = 1'b0;
    rst_i = 1'b1;
    start_sweep(8'd1, 8'd1, 4'd1);
    check("t4_go_after_rst", 32'(busy_o), 32'd1);
    check("t4_start_after_rst", 32'(dev_start_o), 32'd1);
    tick(3);
    rst_i = 1'b0;
    #1;
    check("t4_ack_rst_start", 32'(dev_start_o), 32'd0);
    check("t4_ack_rst_busy", 32'(busy_o), 32'd0);
    tick(2);
    rst_i = 1'b1;
    tick(1);
    check("t4_no_push", 32'(fifo_empty_o), 32'd1);
    dev_lat = 1;

    // Device never answers.
`ifdef Y_REQ_TIMEOUT_EN
    d0 = done_cnt;
    start_sweep(8'd1, 8'd2, 4'd3);
    c0 = cyc;
    wait_done(100);
    check("t5_done_delay", 32'(cyc - c0), 32'd17);
    check("t5_err", 32'(err_o), 32'd1);
    check("t5_start", 32'(dev_start_o), 32'd0);
    check("t5_empty", 32'(fifo_empty_o), 32'd1);
    tick(2);
    check("t5_idle", 32'(busy_o), 32'd0);
    check("t5_dones", 32'(done_cnt - d0), 32'd1);
    dev_en = 1'b1;
    start_sweep(8'd2, 8'd4, 4'd1);
    check("t5_err_cleared", 32'(err_o), 32'd0);
    wait_done(100);
    tick(1);
    pop_check("t5_res", dres(8'd2, 8'd4));
`else
    c0 = cyc;
    start_sweep(8'd1, 8'd2, 4'd3);
    tick(40);
    check("t5_still_busy", 32'(busy_o), 32'd1);
    check("t5_still_start", 32'(dev_start_o), 32'd1);
    check("t5_err_zero", 32'(err_o), 32'd0);
    check("t5_elapsed", 32'(cyc - c0 >= 40), 32'd1);
    rst_i = 1'b0;
    tick(2);
    rst_i = 1'b1;
    dev_en = 1'b1;
    tick(1);
    check("t5_idle", 32'(busy_o), 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
